// File: rtl/serial_instr_rx.sv
// Bit-serial instruction receiver: 4-phase data_ready/data_ack per bit, optional even parity,
// stall timeout, saturating error counter and a valid/ready word output with backpressure.
module serial_instr_rx #(
  parameter int WIDTH       = 10,
  parameter int PARITY_EN   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_ready,
  input  logic             data_bit,
  output logic             data_ack,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             parity_err,
  output logic             timeout_err,
  output logic [7:0]       err_count,
  output logic [1:0]       state
);

  localparam int FRAME = WIDTH + PARITY_EN;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SAMPLE = 2'd1,
    S_ACK    = 2'd2,
    S_ABORT  = 2'd3
  } state_t;

  state_t                 st;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic [SYNC_STAGES-1:0] bit_sync;
  logic                   rdy_s;
  logic                   bit_s;
  logic [WIDTH-1:0]       shreg;
  logic                   par_bit;
  logic [CNT_W-1:0]       bit_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   last_bit;
  logic                   frame_done;
  logic                   stall;
  logic                   tmo_hit;
  logic                   par_ok;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage: pin synchronisers; only the last flop of each chain is used downstream
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_sync <= '0;
      bit_sync <= '0;
    end else begin
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], data_ready};
      bit_sync <= {bit_sync[SYNC_STAGES-2:0], data_bit};
    end
  end

  assign rdy_s      = rdy_sync[SYNC_STAGES-1];
  assign bit_s      = bit_sync[SYNC_STAGES-1];
  assign last_bit   = (bit_cnt == CNT_W'(FRAME - 1));
  assign frame_done = (bit_cnt == CNT_W'(FRAME));
  // Hold the final bit unacked while an unconsumed word would otherwise be overwritten
  assign stall      = last_bit && instr_valid && !instr_ready;
  assign tmo_hit    = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign par_ok     = (PARITY_EN == 0) || ((^shreg ^ par_bit) == 1'b0);
  assign state      = st;

  // Stage: handshake FSM, frame assembly, commit and error reporting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st          <= S_WAIT;
      data_ack    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      err_count   <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      if (instr_valid && instr_ready) instr_valid <= 1'b0;

      case (st)
        S_WAIT: begin
          data_ack <= 1'b0;
          if (rdy_s) begin
            st      <= S_SAMPLE;
            tmo_cnt <= '0;
          end else if (bit_cnt != '0) begin
            if (tmo_hit) begin
              st          <= S_ABORT;
              timeout_err <= 1'b1;
              err_count   <= sat_inc(err_count);
              bit_cnt     <= '0;
              shreg       <= '0;
              par_bit     <= 1'b0;
              tmo_cnt     <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end
        end

        S_SAMPLE: begin
          if (!stall) begin
            if (bit_cnt < CNT_W'(WIDTH)) shreg <= {shreg[WIDTH-2:0], bit_s};
            else                         par_bit <= bit_s;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            data_ack <= 1'b1;
            st       <= S_ACK;
            tmo_cnt  <= '0;
          end
        end

        S_ACK: begin
          if (!rdy_s) begin
            data_ack <= 1'b0;
            st       <= S_WAIT;
            tmo_cnt  <= '0;
            if (frame_done) begin
              bit_cnt <= '0;
              shreg   <= '0;
              par_bit <= 1'b0;
              if (par_ok) begin
                instr       <= shreg;
                instr_valid <= 1'b1;
              end else begin
                parity_err <= 1'b1;
                err_count  <= sat_inc(err_count);
              end
            end
          end else if (tmo_hit) begin
            st          <= S_ABORT;
            data_ack    <= 1'b0;
            timeout_err <= 1'b1;
            err_count   <= sat_inc(err_count);
            bit_cnt     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        S_ABORT: begin
          data_ack <= 1'b0;
          if (!rdy_s) begin
            st      <= S_WAIT;
            tmo_cnt <= '0;
          end
        end

        default: st <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_instr_rx.sv
// Directed bench for serial_instr_rx: WIDTH=10, even parity, 2 sync stages, TIMEOUT=16.
module tb_serial_instr_rx;
  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             data_ready = 1'b0;
  logic             data_bit = 1'b0;
  logic             instr_ready = 1'b0;
  logic             data_ack;
  logic [WIDTH-1:0] instr;
  logic             instr_valid;
  logic             parity_err;
  logic             timeout_err;
  logic [7:0]       err_count;
  logic [1:0]       state;

  int               n_pass = 0;
  int               n_total = 0;
  int               perr_n = 0;
  int               terr_n = 0;
  logic [WIDTH-1:0] rx_q[$];

  serial_instr_rx #(
    .WIDTH(10), .PARITY_EN(1), .SYNC_STAGES(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data_ready(data_ready), .data_bit(data_bit),
    .data_ack(data_ack), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .parity_err(parity_err), .timeout_err(timeout_err),
    .err_count(err_count), .state(state)
  );

  always #5 clk = ~clk;

  // Consumer side: record transfers and error pulses as the DUT presents them on each edge
  always @(posedge clk) begin
    if (instr_valid && instr_ready) rx_q.push_back(instr);
    if (parity_err)  perr_n <= perr_n + 1;
    if (timeout_err) terr_n <= terr_n + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] last_rx();
    return (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : '0;
  endfunction

  function automatic logic [WIDTH-1:0] prev_rx();
    return (rx_q.size() > 1) ? rx_q[rx_q.size()-2] : '0;
  endfunction

  task automatic raise_bit(input logic b, output int lat);
    data_bit   = b;
    data_ready = 1'b1;
    lat        = 0;
    do begin
      tick();
      lat++;
    end while (!data_ack && lat < 60);
    if (!data_ack) check("ack_wait", {31'd0, data_ack}, 32'd1);
  endtask

  task automatic drop_bit();
    int n;
    n = 0;
    data_ready = 1'b0;
    do begin
      tick();
      n++;
    end while (data_ack && n < 60);
    if (data_ack) check("unack_wait", {31'd0, data_ack}, 32'd0);
  endtask

  task automatic send_bits(input logic [31:0] v, input int nb, input bit chk_lat);
    int lat;
    for (int i = nb - 1; i >= 0; i--) begin
      raise_bit(v[i], lat);
      if (chk_lat) check("ack_latency", lat, 32'd4);
      drop_bit();
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic p, input bit chk_lat);
    logic [WIDTH:0] f;
    f = {w, p};
    send_bits({21'd0, f}, WIDTH + 1, chk_lat);
  endtask

  initial begin
    int lat;
    int n;

    // Reset state
    tick();
    check("rst_ack", {31'd0, data_ack}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {22'd0, instr}, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);
    check("rst_state", {30'd0, state}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: good frame 2A5 with parity 1, consumer always ready
    instr_ready = 1'b1;
    send_frame(10'h2A5, 1'b1, 1'b1);
    check("t1_valid", {31'd0, instr_valid}, 32'd1);
    check("t1_instr", {22'd0, instr}, 32'h2A5);
    tick();
    check("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("t1_rx_cnt", rx_q.size(), 32'd1);
    check("t1_rx_word", {22'd0, last_rx()}, 32'h2A5);
    check("t1_no_err", perr_n + terr_n, 32'd0);

    // 2: same word with wrong parity is dropped
    send_frame(10'h2A5, 1'b0, 1'b0);
    check("t2_perr", {31'd0, parity_err}, 32'd1);
    check("t2_valid", {31'd0, instr_valid}, 32'd0);
    check("t2_errcnt", {24'd0, err_count}, 32'd1);
    tick();
    check("t2_perr_pulse", {31'd0, parity_err}, 32'd0);
    check("t2_rx_cnt", rx_q.size(), 32'd1);

    // 3: backpressure stalls the final bit of the next frame
    instr_ready = 1'b0;
    send_frame(10'h001, 1'b1, 1'b0);
    check("t3_valid1", {31'd0, instr_valid}, 32'd1);
    check("t3_instr1", {22'd0, instr}, 32'h001);
    send_bits({22'd0, 10'h3FF}, WIDTH, 1'b0);
    data_bit   = 1'b0;
    data_ready = 1'b1;
    repeat (10) tick();
    check("t3_stall_ack", {31'd0, data_ack}, 32'd0);
    check("t3_stall_state", {30'd0, state}, 32'd1);
    check("t3_stall_noto", terr_n, 32'd0);
    instr_ready = 1'b1;
    tick();
    check("t3_ack_after_ready", {31'd0, data_ack}, 32'd1);
    check("t3_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("t3_rx_word1", {22'd0, last_rx()}, 32'h001);
    instr_ready = 1'b0;
    drop_bit();
    check("t3_valid2", {31'd0, instr_valid}, 32'd1);
    check("t3_instr2", {22'd0, instr}, 32'h3FF);
    instr_ready = 1'b1;
    tick();
    check("t3_rx_cnt", rx_q.size(), 32'd3);
    check("t3_rx_word2", {22'd0, last_rx()}, 32'h3FF);

    // 4: peer stalls in WAIT mid-frame
    send_bits(32'b1011, 4, 1'b0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_err && n < 40);
    check("t4_to_cycles", n, 32'd16);
    check("t4_state_abort", {30'd0, state}, 32'd3);
    check("t4_errcnt", {24'd0, err_count}, 32'd2);
    tick();
    check("t4_to_pulse", {31'd0, timeout_err}, 32'd0);
    check("t4_state_wait", {30'd0, state}, 32'd0);
    send_frame(10'h155, 1'b1, 1'b0);
    check("t4_instr", {22'd0, instr}, 32'h155);
    check("t4_valid", {31'd0, instr_valid}, 32'd1);
    tick();
    check("t4_rx_word", {22'd0, last_rx()}, 32'h155);

    // 5: peer holds data_ready high after an ack
    send_bits(32'b010, 3, 1'b0);
    raise_bit(1'b1, lat);
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_err && n < 40);
    check("t5_to_cycles", n, 32'd16);
    check("t5_ack_low", {31'd0, data_ack}, 32'd0);
    check("t5_errcnt", {24'd0, err_count}, 32'd3);
    check("t5_state_abort", {30'd0, state}, 32'd3);
    data_ready = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (state != 2'd0 && n < 10);
    check("t5_abort_exit", n, 32'd3);
    repeat (20) tick();
    check("t5_idle_no_to", terr_n, 32'd2);

    // 6: asynchronous reset in the middle of a frame
    send_bits(32'b1100, 4, 1'b0);
    raise_bit(1'b1, lat);
    check("t6_ack_before", {31'd0, data_ack}, 32'd1);
    #2;
    reset_n    = 1'b0;
    data_ready = 1'b0;
    #1;
    check("t6_rst_ack", {31'd0, data_ack}, 32'd0);
    check("t6_rst_state", {30'd0, state}, 32'd0);
    check("t6_rst_instr", {22'd0, instr}, 32'd0);
    check("t6_rst_errcnt", {24'd0, err_count}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    send_frame(10'h0F0, 1'b0, 1'b0);
    check("t6_instr", {22'd0, instr}, 32'h0F0);
    tick();
    check("t6_rx_word", {22'd0, last_rx()}, 32'h0F0);

    // 7: previous word consumed as the next frame completes; both words delivered in order
    instr_ready = 1'b0;
    send_frame(10'h123, 1'b0, 1'b0);
    check("t7_valid1", {31'd0, instr_valid}, 32'd1);
    send_bits({22'd0, 10'h0C3}, WIDTH, 1'b0);
    instr_ready = 1'b1;
    raise_bit(1'b0, lat);
    check("t7_final_latency", lat, 32'd4);
    drop_bit();
    check("t7_valid2", {31'd0, instr_valid}, 32'd1);
    check("t7_instr2", {22'd0, instr}, 32'h0C3);
    tick();
    check("t7_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("t7_rx_prev", {22'd0, prev_rx()}, 32'h123);
    check("t7_rx_last", {22'd0, last_rx()}, 32'h0C3);
    check("t7_rx_cnt", rx_q.size(), 32'd7);

    check("total_parity_pulses", perr_n, 32'd1);
    check("total_timeout_pulses", terr_n, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
